// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-stage types and constants.
package pc_fetch_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;
  localparam inst_t NOOP = 32'h47FF041F;
  localparam int FETCH_WIDTH = 2;
endpackage

// File: rtl/pc_inst_select.sv
// pc_inst_select: splits the fetched word into two slots, substituting NOOP in invalid slots.
module pc_inst_select
  import pc_fetch_pkg::*;
(
  input  logic [63:0] data,
  input  logic        odd,
  input  logic        fetch_ok,
  output inst_t       inst1,
  output inst_t       inst2,
  output logic        inst1_valid,
  output logic        inst2_valid
);
  assign inst1_valid = fetch_ok;
  assign inst2_valid = fetch_ok & ~odd;
  assign inst1 = !inst1_valid ? NOOP : odd ? data[63:32] : data[31:0];
  assign inst2 = inst2_valid ? data[63:32] : NOOP;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: two-wide fetch PC with branch redirect and stall hold.
// Define PC_UNALIGNED_FETCH_EN to allow 4-aligned redirect targets (single-instruction fetch).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_is_taken,
  input  addr_t       fu_target_pc,
  input  logic [63:0] Imem2proc_data,
  input  logic        Imem2proc_valid,
  input  logic        rs_stall,
  input  logic        rob_stall,
  input  logic        rat_stall,
  input  logic        memory_structure_hazard_stall,
  input  logic        pc_enable,
  output addr_t       proc2Imem_addr,
  output addr_t       next_PC_out,
  output inst_t       inst1_out,
  output inst_t       inst2_out,
  output logic        inst1_is_valid,
  output logic        inst2_is_valid
);
  addr_t pc, target;
  logic  stall, odd;
  assign stall = rs_stall | rob_stall | rat_stall | memory_structure_hazard_stall
               | ~pc_enable | ~Imem2proc_valid;
`ifdef PC_UNALIGNED_FETCH_EN
  assign odd    = pc[2];
  assign target = fu_target_pc & ~64'h3;
`else
  assign odd    = 1'b0;
  assign target = fu_target_pc & ~64'h7;
`endif
  assign proc2Imem_addr = {pc[63:3], 3'b000};
  assign next_PC_out    = pc + (odd ? 64'd4 : 64'd8);
  always_ff @(posedge clock or negedge reset)
    if (!reset) pc <= RESET_PC;
    else if (branch_is_taken) pc <= target;
    else if (!stall) pc <= next_PC_out;
  pc_inst_select u_sel (
    .data        (Imem2proc_data),
    .odd         (odd),
    .fetch_ok    (~stall & ~branch_is_taken & reset),
    .inst1       (inst1_out),
    .inst2       (inst2_out),
    .inst1_valid (inst1_is_valid),
    .inst2_valid (inst2_is_valid)
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: cycle-by-cycle vector table for pc_fetch plus an asynchronous-reset sequence.
module tb_pc_fetch;
  import pc_fetch_pkg::*;
  logic clock, reset, branch_is_taken, Imem2proc_valid;
  logic rs_stall, rob_stall, rat_stall, memory_structure_hazard_stall, pc_enable;
  addr_t fu_target_pc, proc2Imem_addr, next_PC_out;
  logic [63:0] Imem2proc_data;
  inst_t inst1_out, inst2_out;
  logic inst1_is_valid, inst2_is_valid;
  int checks = 0, failures = 0;

  pc_fetch dut (
    .clock(clock), .reset(reset), .branch_is_taken(branch_is_taken),
    .fu_target_pc(fu_target_pc), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_valid(Imem2proc_valid), .rs_stall(rs_stall), .rob_stall(rob_stall),
    .rat_stall(rat_stall), .memory_structure_hazard_stall(memory_structure_hazard_stall),
    .pc_enable(pc_enable), .proc2Imem_addr(proc2Imem_addr), .next_PC_out(next_PC_out),
    .inst1_out(inst1_out), .inst2_out(inst2_out),
    .inst1_is_valid(inst1_is_valid), .inst2_is_valid(inst2_is_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst_n, en, dv, br;
    logic [3:0] st;
    addr_t tgt;
    logic [63:0] data;
    addr_t addr, npc;
    inst_t i1, i2;
    logic v1, v2;
  } row_t;
  row_t rows[$];

  localparam logic [63:0] D1 = 64'h1234_4567_5678_3456;
  localparam logic [63:0] D2 = 64'h5672_7617_6157_1425;
  localparam inst_t L1 = 32'h5678_3456, H1 = 32'h1234_4567;
  localparam inst_t L2 = 32'h6157_1425, H2 = 32'h5672_7617;

  function automatic row_t mk(logic rst_n, logic en, logic dv, logic [3:0] st, logic br,
                              addr_t tgt, logic [63:0] data, addr_t addr, addr_t npc,
                              inst_t i1, inst_t i2, logic v1, logic v2);
    row_t r;
    r.rst_n = rst_n; r.en = en; r.dv = dv; r.st = st; r.br = br; r.tgt = tgt; r.data = data;
    r.addr = addr; r.npc = npc; r.i1 = i1; r.i2 = i2; r.v1 = v1; r.v2 = v2;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; branch_is_taken = 0; fu_target_pc = '0; Imem2proc_data = D1;
    Imem2proc_valid = 1; rs_stall = 0; rob_stall = 0; rat_stall = 0;
    memory_structure_hazard_stall = 0; pc_enable = 1;
    // st = {rs, rob, rat, mem}
    rows.push_back(mk(0,1,1,4'b0000,0,64'h0,  D1,64'h0,  64'h8,  NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h0,  64'h8,  L1,H1,1,1));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h8,  64'h10, L1,H1,1,1));
    rows.push_back(mk(1,1,1,4'b0010,0,64'h0,  D1,64'h10, 64'h18, NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h10, 64'h18, L1,H1,1,1));
    rows.push_back(mk(1,1,1,4'b1000,0,64'h0,  D1,64'h18, 64'h20, NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0100,0,64'h0,  D1,64'h18, 64'h20, NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0001,0,64'h0,  D1,64'h18, 64'h20, NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h18, 64'h20, L1,H1,1,1));
    rows.push_back(mk(1,1,1,4'b0000,1,64'h100,D1,64'h20, 64'h28, NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h100,64'h108,L1,H1,1,1));
    rows.push_back(mk(1,0,1,4'b0000,0,64'h0,  D1,64'h108,64'h110,NOOP,NOOP,0,0));
    rows.push_back(mk(1,0,1,4'b0000,1,64'h200,D1,64'h108,64'h110,NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,0,4'b0000,0,64'h0,  D2,64'h200,64'h208,NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D2,64'h200,64'h208,L2,H2,1,1));
    rows.push_back(mk(1,1,1,4'b0100,1,64'h104,D1,64'h208,64'h210,NOOP,NOOP,0,0));
`ifdef PC_UNALIGNED_FETCH_EN
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h100,64'h108,H1,NOOP,1,0));
`else
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h100,64'h108,L1,H1,1,1));
`endif
    rows.push_back(mk(1,1,1,4'b0000,1,64'hFFFF_FFFF_FFFF_FFF8,D1,64'h108,64'h110,NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'hFFFF_FFFF_FFFF_FFF8,64'h0,L1,H1,1,1));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h0,  64'h8,  L1,H1,1,1));
    rows.push_back(mk(0,1,1,4'b0000,1,64'h300,D1,64'h0,  64'h8,  NOOP,NOOP,0,0));
    rows.push_back(mk(1,1,1,4'b0000,0,64'h0,  D1,64'h0,  64'h8,  L1,H1,1,1));
    foreach (rows[i]) begin
      @(negedge clock);
      reset = rows[i].rst_n; pc_enable = rows[i].en; Imem2proc_valid = rows[i].dv;
      {rs_stall, rob_stall, rat_stall, memory_structure_hazard_stall} = rows[i].st;
      branch_is_taken = rows[i].br; fu_target_pc = rows[i].tgt; Imem2proc_data = rows[i].data;
      #1;
      check($sformatf("r%0d_addr", i), proc2Imem_addr, rows[i].addr);
      check($sformatf("r%0d_npc", i), next_PC_out, rows[i].npc);
      check($sformatf("r%0d_inst1", i), {32'h0, inst1_out}, {32'h0, rows[i].i1});
      check($sformatf("r%0d_inst2", i), {32'h0, inst2_out}, {32'h0, rows[i].i2});
      check($sformatf("r%0d_v1", i), {63'h0, inst1_is_valid}, {63'h0, rows[i].v1});
      check($sformatf("r%0d_v2", i), {63'h0, inst2_is_valid}, {63'h0, rows[i].v2});
    end
    // mid-cycle reset takes effect without waiting for a clock edge
    @(posedge clock); @(posedge clock);
    #1 check("pre_async_addr", proc2Imem_addr, 64'h10);
    #2 reset = 1'b0;
    #1 check("async_rst_addr", proc2Imem_addr, 64'h0);
    check("async_rst_v1", {63'h0, inst1_is_valid}, 64'h0);
    check("async_rst_inst1", {32'h0, inst1_out}, {32'h0, NOOP});
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check("post_rst_addr", proc2Imem_addr, 64'h8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Two-way fetch-stage program counter for the superscalar out-of-order core. Holds the fetch PC, drives an 8-byte-aligned instruction-memory address, and splits the returned 64-bit word into two 32-bit instructions with valid flags for decode/dispatch. Redirects on taken branches resolved by the functional units. Holds on any back-end or memory stall.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- branch_is_taken  in  1  taken-branch redirect from FU.
- fu_target_pc  in  64  redirect target, used when branch_is_taken=1.
- Imem2proc_data  in  64  instruction word at proc2Imem_addr.
- Imem2proc_valid  in  1  Imem2proc_data valid this cycle.
- rs_stall  in  1  RS full.
- rob_stall  in  1  RoB full.
- rat_stall  in  1  RAT cannot rename.
- memory_structure_hazard_stall  in  1  data access owns memory port this cycle.
- pc_enable  in  1  global fetch enable; 0 holds PC.
- proc2Imem_addr  out  64  {PC[63:3], 3'b000}.
- next_PC_out  out  64  sequential successor of PC.
- inst1_out  out  32  older fetched instruction.
- inst2_out  out  32  younger fetched instruction.
- inst1_is_valid  out  1  inst1_out is real.
- inst2_is_valid  out  1  inst2_out is real.

## Operation
- stall = rs_stall | rob_stall | rat_stall | memory_structure_hazard_stall | ~pc_enable | ~Imem2proc_valid.
- Aligned PC (PC[2]=0): inst1_out = Imem2proc_data[31:0], inst2_out = Imem2proc_data[63:32]; next_PC_out = PC+8.
- Odd PC (PC[2]=1, see Configuration): inst1_out = Imem2proc_data[63:32], inst2 invalid; next_PC_out = PC+4.
- inst1_is_valid = ~stall & ~branch_is_taken & reset; inst2_is_valid likewise, additionally 0 when PC[2]=1.
- An invalid slot drives NOOP (32'h47FF041F) on its inst output.
- PC update priority: reset → RESET_PC; branch_is_taken → fu_target_pc (overrides every stall, including pc_enable=0); stall → hold; else next_PC_out.
- Taken branch squashes the current cycle's fetch (both valids 0).
- PC arithmetic is unsigned 64-bit, wraps modulo 2^64.

## Timing
- Outputs combinational from PC register and inputs; fetch result valid same cycle as address (zero-latency memory model).
- PC advances one cycle after a non-stalled fetch; redirect target appears on proc2Imem_addr the cycle after branch_is_taken.
- Reset asserted (reset=0): PC=RESET_PC immediately; proc2Imem_addr=RESET_PC, next_PC_out=RESET_PC+8, both valids 0, inst outputs NOOP. Mid-operation reset discards any pending redirect.
- Simultaneous branch and stall: branch wins, PC loads target.

## Configuration
- PC_UNALIGNED_FETCH_EN defined: fu_target_pc[2] honored; odd PC fetches single instruction as above. fu_target_pc[1:0] always cleared.
- Not defined: fu_target_pc[2:0] cleared on load, PC always 8-aligned, always dual fetch, next_PC_out = PC+8.

## Structure
- Shared package: NOOP constant, 64-bit address type, 32-bit instruction type, fetch width (2).
- One sub-module natural: pc_inst_select (word split, NOOP substitution, valid generation).

## Test plan
- Reset then run, data 64'h1234_4567_5678_3456 → addr 0, inst1=5678_3456, inst2=1234_4567, both valid; next cycle addr 8, next_PC_out 16.
- rat_stall=1 for one cycle → valids 0, NOOPs driven, addr held; resumes at same addr after release; repeat for rs_stall, rob_stall, memory_structure_hazard_stall.
- branch_is_taken=1, fu_target_pc=64'h100 → valids 0 that cycle; next cycle addr 64'h100, next_PC_out 64'h108.
- pc_enable=0 → addr held, valids 0; pc_enable=0 with branch_is_taken=1 → PC still loads target.
- Imem2proc_valid=0, data 64'h5672_7617_6157_1425 → valids 0, PC held.
- With PC_UNALIGNED_FETCH_EN, target 64'h104 → addr 64'h100, inst1=data[63:32] valid, inst2 invalid, next_PC_out 64'h108; without macro → PC 64'h100, dual fetch.
